// File: rtl/sop_approx_mul_engine.sv
// Programmable sum-of-products approximate multiplier: runtime-loaded product terms per output bit,
// per-result error against the exact product, and a built-in exhaustive worst-case sweep.
module sop_approx_mul_engine #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 4,
    parameter int PPO   = 3,
    parameter int LPP   = 3,
    parameter int ET    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(OUT_W)-1:0] cfg_out,
    input  logic [$clog2(PPO)-1:0]   cfg_term,
    input  logic [2*IN_W-1:0]        cfg_lits,
    output logic                     cfg_err,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_approx,
    output logic [OUT_W-1:0]         out_exact,
    output logic [OUT_W-1:0]         out_err,
    output logic                     out_viol,
    input  logic                     sw_start,
    output logic                     sw_busy,
    output logic                     sw_done,
    output logic [OUT_W-1:0]         sw_max_err,
    output logic [IN_W:0]            sw_viol
);

    localparam int HALF = IN_W / 2;
    localparam int LW   = 2 * IN_W;
    localparam int NT   = OUT_W * PPO;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    state_t state, state_nx;

    logic [LW-1:0]   lits_q [OUT_W][PPO];
    logic            s1_full, s1_sweep;
    logic [NT-1:0]   s1_terms;
    logic [HALF-1:0] s1_a, s1_b;
    logic            s2_full, s2_sweep;
    logic [IN_W-1:0] idx;
    logic            drain_cnt;

    logic            pipe_empty, s2_hold, s1_adv, sw_go, in_fire, inject, s1_load, cfg_ok;
    logic [IN_W-1:0] src;
    logic [NT-1:0]   terms_c;
    logic [OUT_W-1:0] approx_c, exact_c, err_c;
    logic            viol_c;
    int              lit_cnt;

    // Literal codes: 00 absent, 01 true, 10 negated, 11 kills the whole term.
    function automatic logic term_eval(input logic [LW-1:0] l, input logic [IN_W-1:0] x);
        logic t;
        t = 1'b1;
        for (int i = 0; i < IN_W; i++) begin
            case (l[2*i +: 2])
                2'b01:   t = t & x[i];
                2'b10:   t = t & ~x[i];
                2'b11:   t = 1'b0;
                default: t = t;
            endcase
        end
        return t;
    endfunction

    // Sweep results never stall S2; only stream results wait for out_ready.
    assign pipe_empty = ~s1_full & ~s2_full;
    assign s2_hold    = s2_full & ~s2_sweep & ~out_ready;
    assign s1_adv     = s1_full & ~s2_hold;
    assign sw_go      = (state == IDLE) & sw_start & pipe_empty;
    assign in_ready   = (state == IDLE) & ~sw_go & (~s1_full | s1_adv);
    assign in_fire    = in_valid & in_ready;
    assign inject     = (state == SWEEP);
    assign s1_load    = in_fire | inject;
    assign src        = inject ? idx : in_data;
    assign out_valid  = s2_full & ~s2_sweep;
    assign sw_busy    = (state != IDLE);

    always_comb begin
        terms_c = '0;
        for (int o = 0; o < OUT_W; o++)
            for (int p = 0; p < PPO; p++)
                terms_c[o*PPO+p] = term_eval(lits_q[o][p], src);
    end

    always_comb begin
        approx_c = '0;
        for (int o = 0; o < OUT_W; o++)
            approx_c[o] = |s1_terms[o*PPO +: PPO];
        exact_c = OUT_W'(s1_a) * OUT_W'(s1_b);
        err_c   = (exact_c >= approx_c) ? (exact_c - approx_c) : (approx_c - exact_c);
        viol_c  = int'(err_c) > ET;
    end

    always_comb begin
        lit_cnt = 0;
        for (int i = 0; i < IN_W; i++)
            if (cfg_lits[2*i +: 2] == 2'b01 || cfg_lits[2*i +: 2] == 2'b10)
                lit_cnt = lit_cnt + 1;
    end

    assign cfg_ok = cfg_we & (state == IDLE) & pipe_empty & (lit_cnt <= LPP) &
                    (int'(cfg_out) < OUT_W) & (int'(cfg_term) < PPO);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sw_go) state_nx = SWEEP;
            SWEEP:   if (idx == {IN_W{1'b1}}) state_nx = DRAIN;
            DRAIN:   if (drain_cnt) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            drain_cnt <= 1'b0;
            sw_done   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            if (sw_go)       idx <= '0;
            else if (inject) idx <= idx + 1'b1;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            sw_done   <= (state == DRAIN) & drain_cnt;
            cfg_err   <= cfg_we & ~cfg_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < OUT_W; o++)
                for (int p = 0; p < PPO; p++)
                    lits_q[o][p] <= '1;
        end else if (cfg_ok) begin
            lits_q[cfg_out][cfg_term] <= cfg_lits;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_full  <= 1'b0;
            s1_sweep <= 1'b0;
            s1_terms <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_full <= s1_load | (s1_full & ~s1_adv);
            if (s1_load) begin
                s1_sweep <= inject;
                s1_terms <= terms_c;
                s1_a     <= src[HALF-1:0];
                s1_b     <= src[IN_W-1:HALF];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_full    <= 1'b0;
            s2_sweep   <= 1'b0;
            out_approx <= '0;
            out_exact  <= '0;
            out_err    <= '0;
            out_viol   <= 1'b0;
        end else if (s1_adv) begin
            s2_full    <= 1'b1;
            s2_sweep   <= s1_sweep;
            out_approx <= approx_c;
            out_exact  <= exact_c;
            out_err    <= err_c;
            out_viol   <= viol_c;
        end else if (!s2_hold) begin
            s2_full <= 1'b0;
        end
    end

    // Statistics fold in each sweep result as it sits in S2.
    always_ff @(posedge clk) begin
        if (rst || sw_go) begin
            sw_max_err <= '0;
            sw_viol    <= '0;
        end else if (s2_full && s2_sweep) begin
            if (out_err > sw_max_err) sw_max_err <= out_err;
            sw_viol <= sw_viol + (IN_W+1)'(out_viol);
        end
    end

endmodule

// File: tb/tb_sop_approx_mul_engine.sv
// Randomised bench for sop_approx_mul_engine: stream results are scoreboarded against an
// arithmetic model of the SOP table; sweep statistics are recomputed by enumerating every input.
module tb_sop_approx_mul_engine;

    localparam int IN_W  = 4;
    localparam int OUT_W = 4;
    localparam int PPO   = 3;
    localparam int LPP   = 3;
    localparam int ET    = 4;
    localparam int W     = 3*OUT_W + 1;
    localparam int OB    = $clog2(OUT_W);
    localparam int TB    = $clog2(PPO);

    logic                clk, rst;
    logic                cfg_we;
    logic [OB-1:0]       cfg_out;
    logic [TB-1:0]       cfg_term;
    logic [2*IN_W-1:0]   cfg_lits;
    logic                cfg_err;
    logic                in_valid, in_ready;
    logic [IN_W-1:0]     in_data;
    logic                out_valid, out_ready;
    logic [OUT_W-1:0]    out_approx, out_exact, out_err;
    logic                out_viol;
    logic                sw_start, sw_busy, sw_done;
    logic [OUT_W-1:0]    sw_max_err;
    logic [IN_W:0]       sw_viol;

    sop_approx_mul_engine #(.IN_W(IN_W), .OUT_W(OUT_W), .PPO(PPO), .LPP(LPP), .ET(ET)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_out(cfg_out), .cfg_term(cfg_term), .cfg_lits(cfg_lits), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_approx(out_approx), .out_exact(out_exact), .out_err(out_err), .out_viol(out_viol),
        .sw_start(sw_start), .sw_busy(sw_busy), .sw_done(sw_done),
        .sw_max_err(sw_max_err), .sw_viol(sw_viol)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int               n_checks = 0;
    int               n_errors = 0;
    int               n_out = 0;
    logic [W-1:0]     exp_q[$];
    logic [2*IN_W-1:0] m_lits [OUT_W][PPO];
    bit               hs_in = 0;
    bit               prev_stall = 0;
    logic [W-1:0]     prev_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int lit_count(input logic [2*IN_W-1:0] l);
        int n = 0;
        for (int i = 0; i < IN_W; i++)
            if (l[2*i +: 2] == 2'b01 || l[2*i +: 2] == 2'b10) n++;
        return n;
    endfunction

    // Reference: a is the low half of the input, b the high half; plain integer arithmetic.
    function automatic logic [W-1:0] model(input logic [IN_W-1:0] x);
        int a, b, ex, ap, er, c;
        bit hit, t;
        logic [2*IN_W-1:0] l;
        a  = int'(x) % (1 << (IN_W/2));
        b  = int'(x) / (1 << (IN_W/2));
        ex = (a * b) % (1 << OUT_W);
        ap = 0;
        for (int o = 0; o < OUT_W; o++) begin
            hit = 0;
            for (int p = 0; p < PPO; p++) begin
                l = m_lits[o][p];
                t = 1;
                for (int i = 0; i < IN_W; i++) begin
                    c = int'(l[2*i +: 2]);
                    if (c == 3) t = 0;
                    else if (c == 1 && !x[i]) t = 0;
                    else if (c == 2 && x[i]) t = 0;
                end
                if (t) hit = 1;
            end
            if (hit) ap += (1 << o);
        end
        er = (ex > ap) ? ex - ap : ap - ex;
        return {OUT_W'(ap), OUT_W'(ex), OUT_W'(er), er > ET};
    endfunction

    task automatic model_reset();
        for (int o = 0; o < OUT_W; o++)
            for (int p = 0; p < PPO; p++)
                m_lits[o][p] = '1;
        exp_q.delete();
        prev_stall = 0;
    endtask

    // One clock: observe handshakes mid-cycle, then return just after the next rising edge.
    task automatic tick();
        logic [W-1:0] obs;
        @(negedge clk);
        hs_in = 0;
        if (!rst) begin
            obs = {out_approx, out_exact, out_err, out_viol};
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'(obs), 32'(prev_out));
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data));
                hs_in = 1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
                else begin
                    check("stream_out", 32'(obs), 32'(exp_q.pop_front()));
                    n_out++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = obs;
        end else begin
            prev_stall = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1; in_valid = 0; in_data = '0; out_ready = 1;
        cfg_we = 0; cfg_out = '0; cfg_term = '0; cfg_lits = '0; sw_start = 0;
        tick();
        tick();
        rst = 0;
        model_reset();
    endtask

    task automatic cfg_write(input int o, input int t, input logic [2*IN_W-1:0] l, input bit ctx_ok);
        bit acc;
        acc = ctx_ok && (lit_count(l) <= LPP);
        cfg_out = OB'(o); cfg_term = TB'(t); cfg_lits = l; cfg_we = 1;
        tick();
        cfg_we = 0;
        check("cfg_err", 32'(cfg_err), 32'(!acc));
        if (acc) m_lits[o][t] = l;
        tick();
        check("cfg_err_pulse", 32'(cfg_err), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 0;
        out_ready = 1;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_sweep(input bit cfg_mid);
        int e_max = 0, e_viol = 0, cycles = 0;
        bit done = 0;
        logic [W-1:0] r;
        for (int x = 0; x < (1 << IN_W); x++) begin
            r = model(IN_W'(x));
            if (int'(r[OUT_W:1]) > e_max) e_max = int'(r[OUT_W:1]);
            if (r[0]) e_viol++;
        end
        sw_start = 1;
        tick();
        sw_start = 0;
        check("sw_busy_start", 32'(sw_busy), 32'd1);
        while (!done && cycles < 100) begin
            cfg_we = cfg_mid && (cycles == 3);
            cfg_out = '0; cfg_term = '0; cfg_lits = 8'h01;
            tick();
            cfg_we = 0;
            cycles++;
            if (cfg_mid && cycles == 4) check("cfg_err_sweep", 32'(cfg_err), 32'd1);
            if (sw_done) done = 1;
        end
        check("sw_cycles", 32'(cycles), 32'((1 << IN_W) + 2));
        check("sw_max_err", 32'(sw_max_err), 32'(e_max));
        check("sw_viol", 32'(sw_viol), 32'(e_viol));
        tick();
        check("sw_done_pulse", 32'(sw_done), 32'd0);
        check("sw_busy_end", 32'(sw_busy), 32'd0);
    endtask

    task automatic single(input logic [IN_W-1:0] d, input int ap, input int ex, input int er, input int vi);
        in_data = d; in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        check("lat2_valid", 32'(out_valid), 32'd1);
        check("lat2_approx", 32'(out_approx), 32'(ap));
        check("lat2_exact", 32'(out_exact), 32'(ex));
        check("lat2_err", 32'(out_err), 32'(er));
        check("lat2_viol", 32'(out_viol), 32'(vi));
        tick();
    endtask

    initial begin
        logic [IN_W-1:0] dl [3];
        logic [2*IN_W-1:0] l;
        int k, n0, r, guard;

        reset_dut();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_sw_busy", 32'(sw_busy), 32'd0);
        check("rst_sw_done", 32'(sw_done), 32'd0);
        check("rst_sw_max", 32'(sw_max_err), 32'd0);
        check("rst_sw_viol", 32'(sw_viol), 32'd0);
        check("rst_out_data", 32'({out_approx, out_exact, out_err, out_viol}), 32'd0);

        // All terms killed: approx is 0 so error equals exact product.
        run_sweep(0);
        check("t1_max", 32'(sw_max_err), 32'd9);
        check("t1_viol", 32'(sw_viol), 32'd3);

        cfg_write(0, 0, 8'h11, 1);
        single(4'b0101, 1, 1, 0, 0);
        single(4'b1111, 1, 9, 8, 1);

        dl[0] = 4'h6; dl[1] = 4'hB; dl[2] = 4'h3;
        out_ready = 0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (k < 3);
            in_data = dl[(k < 3) ? k : 0];
            tick();
            if (hs_in) k++;
        end
        check("t4_accepted", 32'(k), 32'd2);
        check("t4_in_ready", 32'(in_ready), 32'd0);
        cfg_write(1, 0, 8'h04, 0);
        n0 = n_out;
        out_ready = 1;
        guard = 0;
        while (k < 3 && guard < 10) begin
            in_data = dl[k]; in_valid = 1;
            tick();
            if (hs_in) k++;
            guard++;
        end
        drain();
        check("t4_count", 32'(n_out - n0), 32'd3);

        cfg_write(2, 1, 8'h55, 1);
        for (int i = 0; i < 6; i++) begin
            in_data = IN_W'($urandom); in_valid = 1;
            tick();
        end
        drain();
        run_sweep(1);

        for (int w = 0; w < 14; w++) begin
            for (int i = 0; i < IN_W; i++) begin
                r = $urandom_range(0, 9);
                l[2*i +: 2] = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            end
            cfg_write($urandom_range(0, OUT_W-1), $urandom_range(0, PPO-1), l, 1);
        end
        for (int c = 0; c < 300; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = IN_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
        run_sweep(0);

        sw_start = 1;
        tick();
        sw_start = 0;
        for (int c = 0; c < 7; c++) tick();
        rst = 1;
        tick();
        check("t6_sw_busy", 32'(sw_busy), 32'd0);
        check("t6_sw_max", 32'(sw_max_err), 32'd0);
        check("t6_sw_viol", 32'(sw_viol), 32'd0);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        rst = 0;
        model_reset();
        run_sweep(0);
        check("t6_max", 32'(sw_max_err), 32'd9);
        check("t6_viol", 32'(sw_viol), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
